// File: rtl/systolic_sample_sequencer_if.sv
// Bundle between the sample sequencer, its controller and the systolic array.
// The master side loads samples, starts runs, drives the array output and
// collects results. The slave side is the sequencer itself.
interface systolic_sample_sequencer_if #(
    parameter int N  = 8,
    parameter int DW = 16
);
    localparam int AW = $clog2(N);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          done;
    logic [DW-1:0] xin;
    logic          donext;
    logic [DW-1:0] yout;
    logic [2*DW-1:0] res_data;
    logic          res_valid;
    logic [7:0]    res_idx;

    modport master (
        output wr_en, wr_addr, wr_data, start, yout,
        input  busy, done, xin, donext, res_data, res_valid, res_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, yout,
        output busy, done, xin, donext, res_data, res_valid, res_idx
    );
endinterface

// File: rtl/systolic_sample_sequencer.sv
// Replays an N-entry sample buffer ROUNDS times into the systolic array,
// one sample every PERIOD clocks, and captures the sign-extended array
// output at each strobe.
//
// state | meaning
// IDLE  | buffer writable, waiting for start
// RUN   | strobing samples into the array
// DONE  | one-cycle done pulse, then back to IDLE
module systolic_sample_sequencer #(
    parameter int N      = 8,
    parameter int DW     = 16,
    parameter int PERIOD = 30,
    parameter int ROUNDS = 3
) (
    input  logic clk30x,
    input  logic rst_n,
    systolic_sample_sequencer_if.slave bus
);
    localparam int AW    = $clog2(N);
    localparam int CW    = $clog2(PERIOD);
    localparam int TOTAL = ROUNDS * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   mem [N];
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   ptr;
    logic [7:0]      k;
    logic [DW-1:0]   xin_q;
    logic            donext_q;
    logic            busy_q;
    logic            done_q;
    logic [2*DW-1:0] res_data_q;
    logic            res_valid_q;
    logic [7:0]      res_idx_q;

    // Sample buffer: writable only while idle; never cleared by reset.
    always_ff @(posedge clk30x) begin
        if (rst_n && state == IDLE && bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Run sequencing: period counter, strobe generation and result capture.
    always_ff @(posedge clk30x) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= '0;
            k           <= '0;
            xin_q       <= '0;
            donext_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= '0;
        end else begin
            donext_q    <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        cnt    <= '0;
                        ptr    <= '0;
                        k      <= '0;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (cnt == CW'(PERIOD - 1)) begin
                        cnt         <= '0;
                        donext_q    <= 1'b1;
                        xin_q       <= mem[ptr];
                        // yout still reflects the array before this sample lands.
                        res_data_q  <= {{DW{bus.yout[DW-1]}}, bus.yout};
                        res_valid_q <= 1'b1;
                        res_idx_q   <= k;
                        ptr         <= ptr + 1'b1;
                        k           <= k + 8'd1;
                        if (k == 8'(TOTAL - 1)) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.xin       = xin_q;
    assign bus.donext    = donext_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_idx   = res_idx_q;
endmodule

// File: tb/tb_systolic_sample_sequencer.sv
// Bench for the systolic sample sequencer. Expected strobes are queued when a
// run starts; a monitor on the falling edge pops and compares each strobe and
// done pulse. The array is stood in for by a table-driven yout.
module tb_systolic_sample_sequencer;
    localparam int N      = 8;
    localparam int DW     = 16;
    localparam int PERIOD = 30;
    localparam int ROUNDS = 3;
    localparam int TOTAL  = ROUNDS * N;

    typedef struct {
        int          cyc;
        logic [15:0] xin;
        logic [7:0]  idx;
        logic [31:0] rd;
    } exp_t;

    logic clk30x = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   nstrobe = 0;
    int   ybase = 0;
    exp_t exp_q[$];
    int   done_q[$];

    systolic_sample_sequencer_if #(.N(N), .DW(DW)) bus ();

    systolic_sample_sequencer #(
        .N(N), .DW(DW), .PERIOD(PERIOD), .ROUNDS(ROUNDS)
    ) dut (
        .clk30x(clk30x),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk30x = ~clk30x;

    always @(posedge clk30x) cyc++;

    // Array output seen at strobe j of a run, and its sign-extended capture.
    function automatic logic [15:0] ytab(int i);
        case (i)
            0: return 16'h0000;
            1: return 16'hFFFE;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h1234;
            5: return 16'hABCD;
            6: return 16'h0001;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [31:0] rtab(int i);
        case (i)
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFE;
            2: return 32'h0000_7FFF;
            3: return 32'hFFFF_8000;
            4: return 32'h0000_1234;
            5: return 32'hFFFF_ABCD;
            6: return 32'h0000_0001;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    assign bus.yout = ytab((nstrobe - ybase) % 8);

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every strobe and done pulse is matched against the scoreboard.
    always @(negedge clk30x) begin
        if (bus.donext || bus.res_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_donext", 32'(bus.donext), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("donext", 32'(bus.donext), 32'd1);
                check("res_valid", 32'(bus.res_valid), 32'd1);
                check("xin", 32'(bus.xin), 32'(e.xin));
                check("res_idx", 32'(bus.res_idx), 32'(e.idx));
                check("res_data", bus.res_data, e.rd);
            end
            if (bus.donext) nstrobe++;
        end
        if (bus.done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                check("done_cycle", cyc, done_q.pop_front());
                check("busy_at_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic push_run(int p);
        exp_t e;
        for (int j = 0; j < TOTAL; j++) begin
            e.cyc = p + PERIOD * (j + 1);
            e.xin = 16'((j % N) + 1);
            e.idx = 8'(j);
            e.rd  = rtab(j % 8);
            exp_q.push_back(e);
        end
        done_q.push_back(p + PERIOD * TOTAL + 1);
    endtask

    task automatic check_idle(string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_donext"}, 32'(bus.donext), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        check({tag, "_xin"}, 32'(bus.xin), 32'd0);
        check({tag, "_res_idx"}, 32'(bus.res_idx), 32'd0);
        check({tag, "_res_data"}, bus.res_data, 32'd0);
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while (done_q.size() != 0 && n < PERIOD * TOTAL + 50) begin
            @(negedge clk30x);
            n++;
        end
        if (done_q.size() != 0) check({tag, "_timeout"}, 32'(done_q.size()), 32'd0);
    endtask

    task automatic wait_strobes(string tag, int cnt_req);
        int n = 0;
        while ((nstrobe - ybase) < cnt_req && n < PERIOD * TOTAL + 50) begin
            @(negedge clk30x);
            n++;
        end
        if ((nstrobe - ybase) < cnt_req) check({tag, "_timeout"}, 32'(nstrobe - ybase), 32'(cnt_req));
    endtask

    initial begin
        int p;
        int n;
        rst_n       = 1'b0;
        bus.start   = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset held two cycles with start asserted.
        repeat (2) begin
            @(negedge clk30x);
            check_idle("reset");
        end
        rst_n     = 1'b1;
        bus.start = 1'b0;
        @(negedge clk30x);
        check("post_reset_busy", 32'(bus.busy), 32'd0);

        // Load 1..7, then write the last sample together with start.
        for (int i = 0; i < N - 1; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'(i);
            bus.wr_data = 16'(i + 1);
            @(negedge clk30x);
        end
        bus.wr_addr = 3'd7;
        bus.wr_data = 16'd8;
        bus.start   = 1'b1;
        p = cyc + 1;
        ybase = nstrobe;
        push_run(p);
        @(negedge clk30x);
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check("runA_busy", 32'(bus.busy), 32'd1);

        // Write and start mid-run are ignored.
        wait_strobes("runA_mid", 4);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd3;
        bus.wr_data = 16'hAAAA;
        bus.start   = 1'b1;
        @(negedge clk30x);
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        check("runA_busy_after_ignored", 32'(bus.busy), 32'd1);

        // Back-to-back: start at the done-raising edge is ignored, next edge accepted.
        n = 0;
        while (!(bus.donext && bus.res_idx == 8'd23) && n < PERIOD * TOTAL + 50) begin
            @(negedge clk30x);
            n++;
        end
        check("runA_last_strobe_seen", 32'(bus.donext), 32'd1);
        bus.start = 1'b1;
        @(negedge clk30x);
        check("b2b_done_high", 32'(bus.done), 32'd1);
        check("b2b_start_ignored", 32'(bus.busy), 32'd0);
        p = cyc + 1;
        ybase = nstrobe;
        push_run(p);
        @(negedge clk30x);
        bus.start = 1'b0;
        check("runB_busy", 32'(bus.busy), 32'd1);

        // Reset after strobe 10 of run B: outputs clear, no done pulse.
        wait_strobes("runB_mid", 11);
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        @(negedge clk30x);
        check_idle("midrst");
        rst_n = 1'b1;
        repeat (PERIOD + 5) @(negedge clk30x);
        check("midrst_still_idle", 32'(bus.busy), 32'd0);

        // Fresh run restarts from mem[0] with res_idx 0.
        bus.start = 1'b1;
        p = cyc + 1;
        ybase = nstrobe;
        push_run(p);
        @(negedge clk30x);
        bus.start = 1'b0;
        wait_done("runC");
        @(negedge clk30x);
        check("runC_busy_end", 32'(bus.busy), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passes, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/systolic_sample_sequencer.md
Name: systolic_sample_sequencer

Overview:
Upstream driver for the 8-tap Chebyshev systolic array (systolic_wrapper). It holds an N-entry sample buffer, replays it ROUNDS times into the array's xin/donext inputs at a fixed strobe period, and captures the array's yout, sign-extended to 32 bits, at every strobe. It is the synthesizable replacement for the bench-driven stimulus and capture around the array.

Parameters:
N, 8, number of buffered samples (power of 2, matches array taps)
DW, 16, sample/result width at the array interface
PERIOD, 30, clk30x cycles between donext strobes (>=2)
ROUNDS, 3, passes over the buffer per run (total strobes = ROUNDS*N)

Ports:
clk30x  in  1  system clock, all logic on rising edge
rst_n  in  1  reset: one clock, synchronous, active-low
wr_en  in  1  buffer write strobe (accepted only in IDLE)
wr_addr  in  log2(N)  buffer write address
wr_data  in  DW  sample to store
start  in  1  begin run (accepted only in IDLE)
busy  out  1  high from the cycle after start through the final strobe
done  out  1  one-cycle pulse, cycle after the final donext
xin  out  DW  sample to array, registered
donext  out  1  one-cycle strobe to array, coincident with new xin
yout  in  DW  array output, two's complement
res_data  out  2*DW  sign-extended yout captured at each strobe
res_valid  out  1  one-cycle pulse, coincident with donext
res_idx  out  8  strobe number 0..ROUNDS*N-1 of current res_data

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; xin, donext, busy, done, res_data, res_valid, res_idx, period counter cnt, read pointer ptr and strobe count k all cleared to 0. Buffer contents are not cleared. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: wr_en writes mem[wr_addr]<=wr_data. start=1 -> RUN, cnt<=0, ptr<=0, k<=0, busy<=1. If wr_en and start occur together, the write completes and the run starts.
- RUN: cnt increments every cycle. At the edge where cnt==PERIOD-1 (the strobe edge): donext<=1, xin<=mem[ptr], res_data<={DW{yout[DW-1]}, yout}, res_valid<=1, res_idx<=k, ptr<=ptr+1 mod N, k<=k+1, cnt<=0. donext and res_valid drop on the next edge.
- The first donext is high in cycle PERIOD+1 after the start edge. Strobes are spaced exactly PERIOD cycles apart.
- The yout captured at strobe k reflects the array state before sample k is applied. Strobe 0 therefore captures the post-reset array output, and downstream logic interprets the array latency.
- The strobe edge with k==ROUNDS*N-1 moves the FSM to DONE and clears busy.
- DONE lasts one cycle: done<=1, then IDLE with done<=0. xin holds the last sample. donext stays 0 while not in RUN.
- In RUN/DONE, wr_en and start are ignored; the buffer is not modified.
- ptr wraps from N-1 to 0 with no gap. The sample sequence is mem[0..N-1] repeated ROUNDS times.
- Sign extension: res_data[2*DW-1:DW] = all ones when yout[DW-1]=1, else zeros.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> all outputs 0, busy stays 0, no donext.
- Basic run (PERIOD=30): load mem={0x0001..0x0008}, start -> 24 donext pulses. The first is in cycle 31, then every 30 cycles. xin sequence is 1..8,1..8,1..8. Each donext is one cycle wide. done is high in the cycle after the 24th donext. busy is low from then on.
- Sign extension: force yout=0xFFFE at a strobe -> res_data=0xFFFFFFFE. Force yout=0x7FFF -> res_data=0x00007FFF. res_idx matches the strobe count.
- Ignored commands: during RUN, pulse wr_en (addr 3, data 0xAAAA) and start -> the sequence is unchanged and the run length stays 24. A second run shows mem[3] still holds its original value.
- Reset mid-run: assert rst_n=0 after strobe 10 -> next cycle all outputs 0 and IDLE. No done pulse. A new start restarts from mem[0] with res_idx=0.
- Back-to-back: start asserted in the same cycle that done is high is ignored. start one cycle later is accepted, and its first donext is PERIOD+1 cycles later.
